// File: rtl/regfile_2w2r.sv
// Two-write, two-read register file with per-register pending bits for RAW hazard tracking.
// Optional same-cycle write forwarding and hardwired zero register.
module regfile_2w2r #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              RF_clk,
    input  logic              RF_rst_n,
    input  logic              RF_ena,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic              rdy0,
    output logic              rdy1,
    input  logic              iss_vld,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic              wen0;
    logic              wen1;
    logic              iss_ok;

    // Writes and issues to the hardwired zero register are dropped entirely.
    assign wen0   = RF_ena && we0 && !(ZERO_REG && (wa0 == '0));
    assign wen1   = RF_ena && we1 && !(ZERO_REG && (wa1 == '0));
    assign iss_ok = RF_ena && iss_vld && !(ZERO_REG && (iss_addr == '0));

    // Clear on writeback first so a same-edge issue to the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (wen0) pend_d[wa0] = 1'b0;
        if (wen1) pend_d[wa1] = 1'b0;
        if (iss_ok) pend_d[iss_addr] = 1'b1;
    end

    always_ff @(posedge RF_clk) begin
        if (!RF_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            if (wen0) regs_q[wa0] <= wd0;
            // Port 1 is assigned last so it wins an address collision.
            if (wen1) regs_q[wa1] <= wd1;
            pend_q <= pend_d;
        end
    end

    // Returns {ready, data} for one read address.
    function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [DATA_W:0] r;
        r = '0;
        if (!RF_ena) begin
            r = '0;
        end else if (ZERO_REG && (ra == '0)) begin
            r = {1'b1, {DATA_W{1'b0}}};
        end else if (BYPASS && wen1 && (wa1 == ra)) begin
            r = {1'b1, wd1};
        end else if (BYPASS && wen0 && (wa0 == ra)) begin
            r = {1'b1, wd0};
        end else begin
            r = {!pend_q[ra], regs_q[ra]};
        end
        return r;
    endfunction

    always_comb begin
        {rdy0, rd0} = read_port(ra0);
        {rdy1, rd1} = read_port(ra1);
    end

    assign busy = |pend_q;

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed bench for regfile_2w2r: a forwarding instance and a non-forwarding instance share
// all inputs so bypass and non-bypass timing can be compared on the same vectors.
module tb_regfile_2w2r;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [4:0]  iss_addr;
    logic        iss_vld;

    logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;
    logic        a_rdy0, a_rdy1, b_rdy0, b_rdy1;
    logic        a_busy, b_busy;

    int n_checks;
    int n_errors;

    regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_byp (
        .RF_clk(clk), .RF_rst_n(rst_n), .RF_ena(ena),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .ra0(ra0), .ra1(ra1), .rd0(a_rd0), .rd1(a_rd1), .rdy0(a_rdy0), .rdy1(a_rdy1),
        .iss_vld(iss_vld), .iss_addr(iss_addr), .busy(a_busy)
    );

    regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nobyp (
        .RF_clk(clk), .RF_rst_n(rst_n), .RF_ena(ena),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .ra0(ra0), .ra1(ra1), .rd0(b_rd0), .rd1(b_rd1), .rdy0(b_rdy0), .rdy1(b_rdy1),
        .iss_vld(iss_vld), .iss_addr(iss_addr), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled 1 ns after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; we1 = 1'b0; iss_vld = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; ena = 1'b1;
        we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        iss_vld = 1'b0; iss_addr = '0;
        ra0 = 5'd7; ra1 = 5'd31;

        // Reset then read
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_rd0", a_rd0, 32'h0);
        check("rst_rd1", a_rd1, 32'h0);
        check("rst_rdy0", 32'(a_rdy0), 32'h1);
        check("rst_rdy1", 32'(a_rdy1), 32'h1);
        check("rst_busy", 32'(a_busy), 32'h0);

        // Dual write collision: port 1 wins, both for forwarding and storage
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1111_1111;
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h2222_2222;
        ra0 = 5'd5;
        #1;
        check("dual_fwd_rd0", a_rd0, 32'h2222_2222);
        check("dual_nofwd_rd0", b_rd0, 32'h0);
        tick();
        idle_inputs();
        #1;
        check("dual_byp_rd0", a_rd0, 32'h2222_2222);
        check("dual_nobyp_rd0", b_rd0, 32'h2222_2222);

        // Write to register 0 is dropped and never forwarded
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEAD_BEEF; ra0 = 5'd0;
        #1;
        check("zero_fwd_rd0", a_rd0, 32'h0);
        check("zero_fwd_rdy0", 32'(a_rdy0), 32'h1);
        tick();
        idle_inputs();
        #1;
        check("zero_rd0", a_rd0, 32'h0);
        check("zero_nobyp_rd0", b_rd0, 32'h0);

        // Bypass vs registered read latency
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA5A5_A5A5; ra1 = 5'd9;
        #1;
        check("byp_rd1", a_rd1, 32'hA5A5_A5A5);
        check("nobyp_old_rd1", b_rd1, 32'h0);
        tick();
        idle_inputs();
        #1;
        check("nobyp_new_rd1", b_rd1, 32'hA5A5_A5A5);

        // Scoreboard: issue to register 3
        iss_vld = 1'b1; iss_addr = 5'd3; ra0 = 5'd3;
        #1;
        check("iss_same_cycle_rdy0", 32'(a_rdy0), 32'h1);
        tick();
        idle_inputs();
        #1;
        check("pend_rdy0", 32'(a_rdy0), 32'h0);
        check("pend_busy", 32'(a_busy), 32'h1);
        check("pend_nobyp_rdy0", 32'(b_rdy0), 32'h0);
        tick();
        tick();
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h0000_0033;
        #1;
        check("wb_byp_rdy0", 32'(a_rdy0), 32'h1);
        check("wb_byp_rd0", a_rd0, 32'h0000_0033);
        check("wb_nobyp_rdy0", 32'(b_rdy0), 32'h0);
        tick();
        idle_inputs();
        #1;
        check("after_wb_rdy0", 32'(a_rdy0), 32'h1);
        check("after_wb_nobyp_rdy0", 32'(b_rdy0), 32'h1);
        check("after_wb_busy", 32'(a_busy), 32'h0);
        check("after_wb_nobyp_rd0", b_rd0, 32'h0000_0033);

        // Issue and writeback of register 3 on the same edge: pending stays set
        iss_vld = 1'b1; iss_addr = 5'd3;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h0000_0044;
        tick();
        idle_inputs();
        #1;
        check("set_wins_rdy0", 32'(a_rdy0), 32'h0);
        check("set_wins_busy", 32'(a_busy), 32'h1);
        check("set_wins_rd0", a_rd0, 32'h0000_0044);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_0045;
        tick();
        idle_inputs();
        #1;
        check("cleanup_busy", 32'(b_busy), 32'h0);

        // Enable gating blocks writes and issues
        ena = 1'b0;
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0000_0055;
        iss_vld = 1'b1; iss_addr = 5'd4; ra0 = 5'd4;
        #1;
        check("ena0_rd0", a_rd0, 32'h0);
        check("ena0_rdy0", 32'(a_rdy0), 32'h0);
        check("ena0_nobyp_rdy0", 32'(b_rdy0), 32'h0);
        tick();
        ena = 1'b1;
        idle_inputs();
        #1;
        check("ena1_rd0", b_rd0, 32'h0);
        check("ena1_rdy0", 32'(b_rdy0), 32'h1);
        check("ena1_busy", 32'(a_busy), 32'h0);

        // Reset mid-operation overrides a concurrent write
        we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h0000_0077; ra0 = 5'd6;
        tick();
        idle_inputs();
        iss_vld = 1'b1; iss_addr = 5'd6;
        tick();
        idle_inputs();
        #1;
        check("mid_rd0", b_rd0, 32'h0000_0077);
        check("mid_rdy0", 32'(a_rdy0), 32'h0);
        check("mid_busy", 32'(a_busy), 32'h1);
        rst_n = 1'b0;
        we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h0000_0099;
        tick();
        rst_n = 1'b1;
        idle_inputs();
        #1;
        check("rst2_rd0", a_rd0, 32'h0);
        check("rst2_nobyp_rd0", b_rd0, 32'h0);
        check("rst2_rdy0", 32'(a_rdy0), 32'h1);
        check("rst2_busy", 32'(a_busy), 32'h0);
        check("rst2_nobyp_busy", 32'(b_busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_2w2r.md
# regfile_2w2r

Parametrised general-purpose register file for the multi-issue CPU datapath, with two write ports, two read ports, optional write-to-read bypass and an optional hardwired zero register. Each register carries a pending bit that is set when a producer instruction issues and cleared on writeback. The decode stage uses the per-port ready flags to stall on RAW hazards.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes and never goes pending.
- BYPASS, 1: 1 = same-cycle write data forwards to read ports and ready flags.

- RF_clk  in  1  clock; all state updates on its rising edge.
- RF_rst_n  in  1  synchronous, active-low reset.
- RF_ena  in  1  block enable; low freezes all state.
- we0, we1  in  1 each  write enables, ports 0 and 1.
- wa0, wa1  in  ADDR_W each  write addresses.
- wd0, wd1  in  DATA_W each  write data.
- ra0, ra1  in  ADDR_W each  read addresses.
- rd0, rd1  out  DATA_W each  read data.
- rdy0, rdy1  out  1 each  operand at ra0 / ra1 is valid (not pending, or forwarded this cycle).
- iss_vld  in  1  a producer issues this cycle; marks iss_addr pending.
- iss_addr  in  ADDR_W  destination of the issuing producer.
- busy  out  1  OR of all pending bits.

## Operation
- Storage: DEPTH x DATA_W flops plus a DEPTH-bit pending vector.
- Reset: on a rising edge with RF_rst_n=0, all registers and all pending bits clear to 0.
  - Reset takes priority over writes, issues and RF_ena.
- Write: on a rising edge with RF_ena=1 and weK=1, reg[waK] <= wdK.
  - Both ports writing the same address: port 1 wins.
  - With ZERO_REG=1, a write to address 0 is dropped.
- Pending set: rising edge with RF_ena=1, iss_vld=1 and iss_addr valid (not 0 when ZERO_REG=1) sets pend[iss_addr].
- Pending clear: any accepted write to address A clears pend[A].
  - Same edge sets and clears the same address: set wins (a new producer issued as the old one retires).
- Read (combinational):
  - RF_ena=0: rdK = 0 and rdyK = 0.
  - ZERO_REG=1 and raK=0: rdK = 0 and rdyK = 1.
  - BYPASS=1 and an enabled write this cycle matches raK: rdK = that write's data (port 1 before port 0), rdyK = 1.
  - Otherwise: rdK = reg[raK] and rdyK = !pend[raK].
- busy = |pend (0 when RF_ena=0 is not required; busy reflects state regardless of RF_ena).
- RF_ena=0 blocks writes and issues. Stored state and pending bits hold.

## Timing
- Write latency: data is visible through a non-bypassed read one cycle after the write edge. With BYPASS=1 it is visible in the same cycle.
- Issue to pending: rdy drops the cycle after the iss_vld edge. A read of iss_addr in the issue cycle itself still sees the old pend value.
- Writeback to ready: with BYPASS=1, rdy is high in the writeback cycle. With BYPASS=0, rdy rises one cycle later.
- Reset values: rdK = 0, rdyK = 1 when RF_ena=1 (nothing pending) or 0 when RF_ena=0, busy = 0.
- No internal multi-cycle sequences: every state change completes in one edge.

## Test plan
- Reset then read: RF_rst_n=0 for 1 edge, RF_ena=1, ra0=7, ra1=31 -> rd0=rd1=0, rdy0=rdy1=1, busy=0.
- Dual write conflict: we0=we1=1, wa0=wa1=5, wd0=0x1111_1111, wd1=0x2222_2222 -> next cycle rd0(ra0=5)=0x2222_2222. Write to reg 0 of 0xDEAD_BEEF -> rd reads 0.
- Bypass: BYPASS=1, we0=1, wa0=9, wd0=0xA5A5_A5A5, ra1=9 same cycle -> rd1=0xA5A5_A5A5 combinationally. With BYPASS=0 -> old value, new value next cycle.
- Scoreboard: iss_vld, iss_addr=3 -> next cycle rdy0(ra0=3)=0 and busy=1. Three cycles later we1=1, wa1=3 -> rdy0=1 that cycle (BYPASS=1), pend[3]=0 after the edge, busy=0. The same edge with iss_vld, iss_addr=3 -> pend stays 1.
- Enable gating: RF_ena=0 with we0=1, wa0=4, wd0=0x55 and iss_vld, iss_addr=4 -> rd0=0, rdy0=0. After RF_ena returns to 1, reg4 is unchanged and pend[4]=0.
- Reset mid-operation: pend[6]=1 and reg6=0x77, then RF_rst_n=0 on the same edge as we0, wa0=6 -> reg6=0, pend[6]=0, busy=0.
